// File: rtl/demux_pkg.sv
// Shared constants, state encoding and rotating-priority pick helper
// for the demux issue scheduler.
package demux_pkg;

    localparam int CH_W   = 2;
    localparam int NUM_CH = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    typedef logic [CH_W:0] pick_t;

    // Returns {found, idx}: first non-busy channel starting at ptr, wrapping.
    function automatic pick_t rr_pick(
        input logic [CH_W-1:0]   ptr,
        input logic [NUM_CH-1:0] busy
    );
        pick_t           r;
        logic [CH_W-1:0] c;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = ptr + CH_W'(i);
            if (!busy[c]) r = {1'b1, c};
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_rr_arbiter.sv
// Combinational 4-way rotating-priority picker over the request vector.
module demux_rr_arbiter
    import demux_pkg::*;
(
    input  logic [CH_W-1:0]   ptr,
    input  logic [NUM_CH-1:0] req,
    output logic [CH_W-1:0]   idx,
    output logic              found
);

    pick_t pick;

    assign pick  = rr_pick(ptr, ~req);
    assign found = pick[CH_W];
    assign idx   = pick[CH_W-1:0];

endmodule

// File: rtl/demux_issue_sched.sv
// Issue scheduler feeding the 1-to-4 demux with registered in/sel/en.
// Optional per-channel saturating counters: DEMUX_ISSUE_SCHED_STATS_EN.
module demux_issue_sched
    import demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CH_W-1:0]   s_dest,
    input  logic              s_dest_vld,
    input  logic [NUM_CH-1:0] ch_busy,
    output logic [DATA_W-1:0] d_in,
    output logic [CH_W-1:0]   d_sel,
    output logic              d_en,
    output logic [CH_W-1:0]   rr_ptr
`ifdef DEMUX_ISSUE_SCHED_STATS_EN
    ,
    output logic [31:0]       ch_cnt
`endif
);

    logic              state;
    logic              state_nxt;
    logic [DATA_W-1:0] pend_data;
    logic [CH_W-1:0]   pend_dest;
    logic              pend_dvld;
    logic [CH_W-1:0]   rr_idx;
    logic              rr_found;
    logic [CH_W-1:0]   target;
    logic              eligible;
    logic              accept;
    logic              issue;

    demux_rr_arbiter u_arb (
        .ptr   (rr_ptr),
        .req   (~ch_busy),
        .idx   (rr_idx),
        .found (rr_found)
    );

    always_comb begin
        target   = pend_dvld ? pend_dest : rr_idx;
        eligible = pend_dvld ? !ch_busy[pend_dest] : rr_found;
        accept   = (state == IDLE) && s_valid && s_ready;
        issue    = (state == PEND) && eligible;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = PEND;
            PEND:    if (issue)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // s_ready is registered so it stays low for the whole reset window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_ready   <= 1'b0;
            pend_data <= '0;
            pend_dest <= '0;
            pend_dvld <= 1'b0;
            d_in      <= '0;
            d_sel     <= '0;
            d_en      <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            state   <= state_nxt;
            s_ready <= (state_nxt == IDLE);
            d_en    <= issue;
            if (accept) begin
                pend_data <= s_data;
                pend_dest <= s_dest;
                pend_dvld <= s_dest_vld;
            end
            if (issue) begin
                d_in  <= pend_data;
                d_sel <= target;
            end
            if (issue && !pend_dvld) begin
                rr_ptr <= target + CH_W'(1);
            end
        end
    end

`ifdef DEMUX_ISSUE_SCHED_STATS_EN
    logic [7:0] cnt [NUM_CH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (d_en && d_sel == CH_W'(i) && cnt[i] != 8'hFF) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    assign ch_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_demux_issue_sched.sv
// Scoreboard bench for demux_issue_sched: directed items, monitor on d_en.
// Define DEMUX_ISSUE_SCHED_STATS_EN to also exercise the counters.
module tb_demux_issue_sched;

    typedef struct packed {
        logic       data;
        logic [1:0] sel;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [0:0] s_data;
    logic [1:0] s_dest;
    logic       s_dest_vld;
    logic [3:0] ch_busy;
    logic [0:0] d_in;
    logic [1:0] d_sel;
    logic       d_en;
    logic [1:0] rr_ptr;
`ifdef DEMUX_ISSUE_SCHED_STATS_EN
    logic [31:0] ch_cnt;
`endif

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    demux_issue_sched #(.DATA_W(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_dest     (s_dest),
        .s_dest_vld (s_dest_vld),
        .ch_busy    (ch_busy),
        .d_in       (d_in),
        .d_sel      (d_sel),
        .d_en       (d_en),
        .rr_ptr     (rr_ptr)
`ifdef DEMUX_ISSUE_SCHED_STATS_EN
        ,
        .ch_cnt     (ch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every d_en strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && d_en === 1'b1) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_d_en sel=%0d in=%0d t=%0t",
                         d_sel, d_in, $time);
            end else begin
                e = exp_q.pop_front();
                if (d_in !== e.data || d_sel !== e.sel) begin
                    errors++;
                    $display("FAIL issue act in=%0d sel=%0d exp in=%0d sel=%0d",
                             d_in, d_sel, e.data, e.sel);
                end
            end
        end
    end

    task automatic send(input logic d, input logic [1:0] dest,
                        input logic dv, input logic [1:0] sel,
                        input bit push);
        bit ok;
        exp_t e;
        ok = 1'b0;
        @(posedge clk);
        #1;
        s_valid    = 1'b1;
        s_data     = d;
        s_dest     = dest;
        s_dest_vld = dv;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout s_ready=%0b exp=1", s_ready);
        end else begin
            if (push) begin
                e.data = d;
                e.sel  = sel;
                exp_q.push_back(e);
            end
            @(posedge clk);
        end
        #1;
        s_valid    = 1'b0;
        s_dest_vld = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        s_valid    = 1'b1;
        s_data     = 1'b1;
        s_dest     = 2'd3;
        s_dest_vld = 1'b0;
        ch_busy    = 4'b0000;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_s_ready", 32'(s_ready), 32'd0);
            chk("rst_d_en", 32'(d_en), 32'd0);
            chk("rst_d_sel", 32'(d_sel), 32'd0);
            chk("rst_rr_ptr", 32'(rr_ptr), 32'd0);
`ifdef DEMUX_ISSUE_SCHED_STATS_EN
            chk("rst_ch_cnt", ch_cnt, 32'd0);
`endif
        end
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Round-robin sweep, s_dest driven with junk to show it is ignored.
        send(1'b1, 2'd3, 1'b0, 2'd0, 1'b1);
        send(1'b0, 2'd2, 1'b0, 2'd1, 1'b1);
        send(1'b1, 2'd0, 1'b0, 2'd2, 1'b1);
        send(1'b1, 2'd1, 1'b0, 2'd3, 1'b1);
        send(1'b0, 2'd3, 1'b0, 2'd0, 1'b1);
        drain();
        chk("rr_sweep_ptr", 32'(rr_ptr), 32'd1);

        // Explicit destination blocked for four cycles.
        ch_busy = 4'b0100;
        send(1'b1, 2'd2, 1'b1, 2'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("expl_busy_d_en", 32'(d_en), 32'd0);
            chk("expl_busy_s_ready", 32'(s_ready), 32'd0);
        end
        ch_busy = 4'b0000;
        drain();
        chk("expl_rr_ptr", 32'(rr_ptr), 32'd1);

        // RR skip over busy channels 1 and 2.
        ch_busy = 4'b0110;
        send(1'b0, 2'd1, 1'b0, 2'd3, 1'b1);
        drain();
        chk("skip_rr_ptr", 32'(rr_ptr), 32'd0);

        // All busy: item held until channel 2 frees.
        ch_busy = 4'b1111;
        send(1'b1, 2'd0, 1'b0, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_d_en", 32'(d_en), 32'd0);
            chk("hold_s_ready", 32'(s_ready), 32'd0);
            chk("hold_rr_ptr", 32'(rr_ptr), 32'd0);
        end
        ch_busy = 4'b1011;
        drain();
        chk("hold_rr_ptr_after", 32'(rr_ptr), 32'd3);

        // Reset while pending: the item must vanish.
        ch_busy = 4'b1111;
        send(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        ch_busy = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_d_en", 32'(d_en), 32'd0);
        end
        chk("midrst_s_ready", 32'(s_ready), 32'd1);
        chk("midrst_rr_ptr", 32'(rr_ptr), 32'd0);

`ifdef DEMUX_ISSUE_SCHED_STATS_EN
        for (int k = 0; k < 300; k++) begin
            send(k[0], 2'd1, 1'b1, 2'd1, 1'b1);
        end
        drain();
        @(negedge clk);
        chk("stats_ch_cnt", ch_cnt, 32'h0000_FF00);
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
